// File: rtl/ddr3_wr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ddr3_wr_pkg
// Purpose  : Shared types, default geometry and encoding helpers for the
//            DDR3 write-burst controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package ddr3_wr_pkg;

  // Controller state: gather a burst, present its address, stream its beats
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // Default geometry (128-bit beats, 16-beat bursts)
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_BURST_LEN  = 16;
  localparam int BYTES_PER_BEAT = DEF_DATA_W / 8;
  localparam int BURST_BYTES    = DEF_BURST_LEN * BYTES_PER_BEAT;

  // Bytes carried by one data beat
  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Byte distance between consecutive burst start addresses
  function automatic int burst_bytes(input int data_w, input int burst_len);
    return burst_len * beat_bytes(data_w);
  endfunction

  // AXI AWLEN field: beats minus one
  function automatic logic [7:0] awlen_enc(input int burst_len);
    return 8'(burst_len - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_wr_burst_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ddr3_wr_burst_buf
// Purpose  : BURST_LEN x DATA_W burst staging register file. One write port
//            indexed by the fill count, one asynchronous read port indexed by
//            the beat being presented. Contents are not reset.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module ddr3_wr_burst_buf #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(BURST_LEN)-1:0] wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [$clog2(BURST_LEN)-1:0] rd_idx,
  output logic [DATA_W-1:0]            rd_data
);

  logic [DATA_W-1:0] mem [BURST_LEN];

  // Capture each popped FIFO word at its fill position
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/ddr3_wr_burst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ddr3_wr_burst_ctrl
// Purpose  : Drains the prefetch write FIFO into BURST_LEN-beat buffers and
//            issues each as one AXI INCR write burst. Burst start addresses
//            advance linearly and wrap inside [ADDR_BASE, ADDR_END).
//            Optional feature macro DDR_WR_TIMEOUT_EN adds a stall counter and
//            a sticky wr_timeout output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module ddr3_wr_burst_ctrl
  import ddr3_wr_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                BURST_LEN = DEF_BURST_LEN,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_END  = 28'h0100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  addr_clr,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  output logic                  axi_wlast,
  input  logic                  axi_wready,
  output logic                  burst_done,
  output logic [31:0]           burst_cnt,
`ifdef DDR_WR_TIMEOUT_EN
  output logic                  wr_timeout,
`endif
  output logic                  busy
);

  localparam int                IDX_W    = $clog2(BURST_LEN);
  localparam int                CNT_W    = IDX_W + 1;
  localparam int                AW1      = ADDR_W + 1;
  localparam int                BB       = burst_bytes(DATA_W, BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BURST_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] next_addr;
  logic [AW1-1:0]    addr_sum;
  logic [ADDR_W-1:0] addr_adv;
  logic              clr_ok;

  assign axi_awlen = awlen_enc(BURST_LEN);
  assign axi_wstrb = '1;
  assign busy      = (state != ST_IDLE);

  // First-word-fall-through pop: only while gathering and room remains
  assign fifo_rd_en = (state == ST_FILL) && fifo_rd_vld && en && (cnt < CNT_FULL);

  // A clear is honoured only while no burst data is held
  assign clr_ok = addr_clr && ((state == ST_IDLE) || ((state == ST_FILL) && (cnt == '0)));

  // Read port looks one beat ahead so axi_wdata can be registered
  assign idx_nxt = idx + IDX_W'(1);
  assign rd_idx  = (state == ST_DATA) ? idx_nxt : '0;

  // Next burst address with one spare bit so the ring-end compare cannot wrap
  always_comb begin
    addr_sum = {1'b0, next_addr} + AW1'(BB);
    addr_adv = (addr_sum >= {1'b0, ADDR_END}) ? ADDR_BASE : addr_sum[ADDR_W-1:0];
  end

  ddr3_wr_burst_buf #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) u_buf (
    .clk     (clk),
    .wr_en   (fifo_rd_en),
    .wr_idx  (cnt[IDX_W-1:0]),
    .wr_data (fifo_rd_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Burst sequencer: fill, address phase, data phase, with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      next_addr   <= ADDR_BASE;
      axi_awaddr  <= ADDR_BASE;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_wdata   <= '0;
      burst_done  <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      burst_done <= 1'b0;
      if (clr_ok) begin
        next_addr <= ADDR_BASE;
      end
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fifo_rd_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state       <= ST_ADDR;
              axi_awvalid <= 1'b1;
              axi_awaddr  <= next_addr;
            end
          end else if (!en && (cnt == '0)) begin
            state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b1;
            axi_wdata   <= rd_data;
            axi_wlast   <= (IDX_LAST == '0);
            idx         <= '0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi_wready) begin
            if (axi_wlast) begin
              axi_wvalid <= 1'b0;
              axi_wlast  <= 1'b0;
              burst_done <= 1'b1;
              burst_cnt  <= burst_cnt + 32'd1;
              cnt        <= '0;
              if (!clr_ok) begin
                next_addr <= addr_adv;
              end
              state <= en ? ST_FILL : ST_IDLE;
            end else begin
              idx       <= idx_nxt;
              axi_wdata <= rd_data;
              axi_wlast <= (idx_nxt == IDX_LAST);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DDR_WR_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        any_hs;
  logic        stalled;

  assign any_hs  = (axi_awvalid && axi_awready) || (axi_wvalid && axi_wready);
  assign stalled = ((state == ST_ADDR) && !axi_awready) ||
                   ((state == ST_DATA) && !axi_wready);

  // Count consecutive stalled cycles; saturation latches a sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      wr_timeout <= 1'b0;
    end else begin
      if (any_hs) begin
        stall_cnt <= '0;
      end else if (stalled && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (stall_cnt == 16'hFFFF) begin
        wr_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_wr_burst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_ddr3_wr_burst_ctrl
// Purpose  : Self-checking bench for ddr3_wr_burst_ctrl with a FIFO model,
//            random AXI backpressure and a transaction-level reference.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ddr3_wr_burst_ctrl;

  localparam int              DW       = 128;
  localparam int              AW       = 28;
  localparam int              BL       = 16;
  localparam logic [AW-1:0]   BASE     = 28'h0;
  localparam logic [AW-1:0]   RING_END = 28'h400;
  localparam int              BB       = BL * DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          addr_clr = 1'b0;
  logic          fifo_rd_en;
  logic          fifo_rd_vld = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready = 1'b1;
  logic [DW-1:0] axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic          axi_wvalid;
  logic          axi_wlast;
  logic          axi_wready = 1'b1;
  logic          burst_done;
  logic [31:0]   burst_cnt;
  logic          busy;
`ifdef DDR_WR_TIMEOUT_EN
  logic          wr_timeout;
`endif

  ddr3_wr_burst_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .ADDR_BASE(BASE), .ADDR_END(RING_END)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .addr_clr(addr_clr),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast), .axi_wready(axi_wready),
    .burst_done(burst_done), .burst_cnt(burst_cnt),
`ifdef DDR_WR_TIMEOUT_EN
    .wr_timeout(wr_timeout),
`endif
    .busy(busy)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: FIFO contents, words held by the DUT, burst bookkeeping
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] popped[$];
  logic [AW-1:0] aw_log[$];
  int            pops, beat, bursts, cyc, first_pop_cyc, last_done_cyc;
  bit            aw_seen, done_pending, any_aw;
  logic [AW-1:0] exp_next;
  bit            prev_aw_stall, prev_w_stall;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;
  logic          prev_wlast;
  bit            rand_ready, en_drv, clr_drv;
  int            aw_hold, w_hold;

  typedef struct {
    bit in_fill;
    bit en;
    bit vld;
    bit exp_rd_en;
  } row_t;
  row_t tbl[8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    fifo_q.delete();
    popped.delete();
    pops = 0; beat = 0; bursts = 0;
    aw_seen = 0; done_pending = 0;
    exp_next = BASE;
    prev_aw_stall = 0; prev_w_stall = 0;
    aw_hold = 0; w_hold = 0;
  endtask

  task automatic push_n(input int n, input bit seq, input int start);
    for (int i = 0; i < n; i++) begin
      if (seq) fifo_q.push_back(DW'(start + i));
      else     fifo_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

  // One clock: drive inputs on the falling edge, check, then advance the model
  task automatic tick();
    int nxt;
    @(negedge clk);
    en       = en_drv;
    addr_clr = clr_drv;
    if (rand_ready) begin
      if (aw_hold > 0) begin axi_awready = 1'b0; aw_hold--; end
      else begin
        axi_awready = 1'b1;
        aw_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      end
      if (w_hold > 0) begin axi_wready = 1'b0; w_hold--; end
      else begin
        axi_wready = 1'b1;
        w_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      end
    end else begin
      axi_awready = 1'b1;
      axi_wready  = 1'b1;
    end
    fifo_rd_vld  = (fifo_q.size() > 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    chk("burst_done", burst_done, done_pending);
    chk("burst_cnt", burst_cnt, bursts);
    if (burst_done) last_done_cyc = cyc;
    if (prev_aw_stall) begin
      chk("aw_stall_valid", axi_awvalid, 1'b1);
      chk("aw_stall_addr", axi_awaddr, prev_awaddr);
    end
    if (prev_w_stall) begin
      chk("w_stall_valid", axi_wvalid, 1'b1);
      chk("w_stall_data", axi_wdata, prev_wdata);
      chk("w_stall_last", axi_wlast, prev_wlast);
    end
    if (fifo_rd_en) begin
      chk("pop_without_vld", fifo_rd_vld, 1'b1);
      chk("pop_during_drain", axi_awvalid | axi_wvalid, 1'b0);
    end
    if (axi_awvalid) begin
      any_aw = 1;
      chk("aw_before_full", pops, BL);
      chk("awaddr", axi_awaddr, exp_next);
    end
    if (axi_wvalid) begin
      chk("w_before_aw", aw_seen, 1'b1);
      if (popped.size() == 0) chk("w_no_data_held", 1'b1, 1'b0);
      else                    chk("wdata", axi_wdata, popped[0]);
      chk("wlast", axi_wlast, beat == BL - 1);
    end
    // Model update for the coming rising edge
    done_pending = 0;
    if (addr_clr && pops == 0) exp_next = BASE;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      if (pops == 0) first_pop_cyc = cyc;
      popped.push_back(fifo_q.pop_front());
      pops++;
    end
    if (axi_awvalid && axi_awready) begin
      aw_seen = 1;
      aw_log.push_back(axi_awaddr);
    end
    if (axi_wvalid && axi_wready) begin
      if (popped.size() > 0) void'(popped.pop_front());
      beat++;
      if (beat == BL) begin
        beat = 0; pops = 0; aw_seen = 0; bursts++; done_pending = 1;
        nxt = int'(exp_next) + BB;
        exp_next = (nxt >= int'(RING_END)) ? BASE : AW'(nxt);
      end
    end
    prev_aw_stall = axi_awvalid && !axi_awready;
    prev_awaddr   = axi_awaddr;
    prev_w_stall  = axi_wvalid && !axi_wready;
    prev_wdata    = axi_wdata;
    prev_wlast    = axi_wlast;
    cyc++;
  endtask

  task automatic run_bursts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (bursts < target && n < budget) begin tick(); n++; end
    chk(name, bursts, target);
  endtask

  task automatic go_idle_clr();
    int n;
    en_drv = 0;
    n = 0;
    tick();
    while (busy && n < 100) begin tick(); n++; end
    chk("reach_idle", busy, 1'b0);
    clr_drv = 1; tick(); clr_drv = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp3[5];
    int n, base;

    reset_model();
    cyc = 0; rand_ready = 0; en_drv = 0; clr_drv = 0;

    // Reset values while rst_n is held low
    #5;
    chk("rst_awvalid", axi_awvalid, 1'b0);
    chk("rst_wvalid", axi_wvalid, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_done", burst_done, 1'b0);
    chk("rst_cnt", burst_cnt, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awaddr", axi_awaddr, BASE);
    chk("rst_wdata", axi_wdata, '0);
    chk("awlen", axi_awlen, 8'd15);
    chk("wstrb", axi_wstrb, {(DW/8){1'b1}});
    @(negedge clk); rst_n = 1'b1;

    // Pop-enable truth table in IDLE then in FILL with an empty buffer
    tbl[0] = '{0, 0, 0, 0}; tbl[1] = '{0, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 0}; tbl[3] = '{0, 1, 0, 0};
    tbl[4] = '{1, 1, 0, 0}; tbl[5] = '{1, 1, 1, 1};
    tbl[6] = '{1, 0, 1, 0}; tbl[7] = '{1, 0, 0, 0};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      en = tbl[i].en; fifo_rd_vld = tbl[i].vld; #1;
      chk("tbl_rd_en", fifo_rd_en, tbl[i].exp_rd_en);
      chk("tbl_busy", busy, tbl[i].in_fill);
    end
    en = 0; fifo_rd_vld = 0;
    en_drv = 1; tick();
    @(negedge clk);
    for (int i = 4; i < 8; i++) begin
      en = tbl[i].en; fifo_rd_vld = tbl[i].vld; #1;
      chk("tbl_rd_en", fifo_rd_en, tbl[i].exp_rd_en);
      chk("tbl_busy", busy, tbl[i].in_fill);
    end
    en = 1; fifo_rd_vld = 0;

    // Test 1: beats 1..16, no backpressure, fixed latency
    push_n(16, 1, 1);
    run_bursts(1, 200, "t1_burst");
    tick();
    chk("t1_latency", last_done_cyc - first_pop_cyc, 33);
    chk("t1_awaddr", aw_log[0], BASE);
    chk("t1_burst_cnt", burst_cnt, 32'd1);

    // Test 2: 48 random beats under random AW/W stalls
    go_idle_clr();
    aw_log.delete();
    rand_ready = 1; en_drv = 1;
    push_n(48, 0, 0);
    run_bursts(bursts + 3, 3000, "t2_bursts");
    chk("t2_aw_count", aw_log.size(), 3);
    for (int i = 0; i < 3 && i < aw_log.size(); i++) chk("t2_awaddr", aw_log[i], AW'(i * BB));

    // Test 3: ring of four bursts wraps on the fifth
    go_idle_clr();
    aw_log.delete();
    en_drv = 1;
    exp3 = '{28'h000, 28'h100, 28'h200, 28'h300, 28'h000};
    push_n(80, 0, 0);
    run_bursts(bursts + 5, 5000, "t3_bursts");
    for (int i = 0; i < 5 && i < aw_log.size(); i++) chk("t3_awaddr", aw_log[i], exp3[i]);
    rand_ready = 0;

    // Test 4: partial fill, long FIFO starvation, then completion
    any_aw = 0;
    push_n(10, 0, 0);
    repeat (60) tick();
    chk("t4_no_aw_partial", any_aw, 1'b0);
    chk("t4_pops_held", pops, 10);
    push_n(6, 0, 0);
    run_bursts(bursts + 1, 300, "t4_burst");

    // Test 5: drop en in the data phase of the second burst, then clear address
    base = bursts;
    push_n(40, 0, 0);
    n = 0;
    while (!(bursts == base + 1 && beat == 3 && axi_wvalid) && n < 500) begin tick(); n++; end
    chk("t5_reach_beat", bursts, base + 1);
    en_drv = 0;
    run_bursts(base + 2, 200, "t5_finish");
    repeat (20) tick();
    chk("t5_idle", busy, 1'b0);
    chk("t5_no_pops", fifo_q.size(), 8);
    clr_drv = 1; tick(); clr_drv = 0;
    push_n(8, 0, 0);
    en_drv = 1;
    run_bursts(base + 3, 300, "t5_after_clr");
    if (aw_log.size() > 0) chk("t5_clr_addr", aw_log[aw_log.size() - 1], BASE);

    // Test 6: reset during beat 7 of a burst, then a fresh burst
    base = bursts;
    push_n(16, 0, 0);
    n = 0;
    while (!(beat == 7 && axi_wvalid) && n < 300) begin tick(); n++; end
    chk("t6_reach_beat", beat, 7);
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid", axi_awvalid, 1'b0);
    chk("t6_wvalid", axi_wvalid, 1'b0);
    chk("t6_rd_en", fifo_rd_en, 1'b0);
    chk("t6_burst_cnt", burst_cnt, 32'd0);
    reset_model();
    aw_log.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_n(16, 0, 0);
    run_bursts(1, 300, "t6_fresh_burst");
    if (aw_log.size() > 0) chk("t6_fresh_addr", aw_log[0], BASE);
    tick();
    chk("t6_fresh_cnt", burst_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
